// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-requester sequencer for a shared external ALU
// Define ALU_ARB_STATS_EN to build the per-requester grant counters.
module alu_arbiter #(
  parameter int W       = 8,
  parameter int ALU_LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_req0,
  input  logic         i_req1,
  input  logic [W-1:0] i_a0,
  input  logic [W-1:0] i_b0,
  input  logic [W-1:0] i_a1,
  input  logic [W-1:0] i_b1,
  input  logic [3:0]   i_sel0,
  input  logic [3:0]   i_sel1,
  input  logic [3:0]   i_sh0,
  input  logic [3:0]   i_sh1,
  output logic         o_ack0,
  output logic         o_ack1,
  output logic [W-1:0] o_res,
  output logic         o_busy,
  output logic [W-1:0] o_alu_a,
  output logic [W-1:0] o_alu_b,
  output logic [3:0]   o_alu_sel,
  output logic [3:0]   o_alu_sh,
  input  logic [W-1:0] i_alu_out,
  output logic [15:0]  o_cnt0,
  output logic [15:0]  o_cnt1
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_last;
  logic         r_gnt;
  logic [3:0]   r_lat;
  logic [W-1:0] r_res;
  logic [W-1:0] r_alu_a;
  logic [W-1:0] r_alu_b;
  logic [3:0]   r_alu_sel;
  logic [3:0]   r_alu_sh;
  logic         w_grant;
  logic         w_gnt_nxt;
  logic         w_capture;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    w_gnt_nxt   = (i_req0 && i_req1) ? ~r_last : i_req1;
    case (r_state)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          w_grant     = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_lat == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last    <= 1'b1;
      r_gnt     <= 1'b0;
      r_lat     <= 4'd0;
      r_res     <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= 4'd0;
      r_alu_sh  <= 4'd0;
    end else begin
      if (w_grant) begin
        r_gnt     <= w_gnt_nxt;
        r_last    <= w_gnt_nxt;
        r_lat     <= 4'(ALU_LAT - 1);
        r_alu_a   <= w_gnt_nxt ? i_a1   : i_a0;
        r_alu_b   <= w_gnt_nxt ? i_b1   : i_b0;
        r_alu_sel <= w_gnt_nxt ? i_sel1 : i_sel0;
        r_alu_sh  <= w_gnt_nxt ? i_sh1  : i_sh0;
      end else if (r_state == S_EXEC && r_lat != 4'd0) begin
        r_lat <= r_lat - 4'd1;
      end
      if (w_capture) r_res <= i_alu_out;
    end
  end

  assign o_ack0    = (r_state == S_DONE) && !r_gnt;
  assign o_ack1    = (r_state == S_DONE) &&  r_gnt;
  assign o_busy    = (r_state != S_IDLE);
  assign o_res     = r_res;
  assign o_alu_a   = r_alu_a;
  assign o_alu_b   = r_alu_b;
  assign o_alu_sel = r_alu_sel;
  assign o_alu_sh  = r_alu_sh;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt0 <= 16'd0;
      r_cnt1 <= 16'd0;
    end else if (w_grant) begin
      if (w_gnt_nxt) r_cnt1 <= r_cnt1 + 16'd1;
      else           r_cnt0 <= r_cnt0 + 16'd1;
    end
  end

  assign o_cnt0 = r_cnt0;
  assign o_cnt1 = r_cnt1;
`else
  assign o_cnt0 = 16'd0;
  assign o_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - bench for alu_arbiter, one instance at ALU_LAT=1 and one at ALU_LAT=4
module tb_alu_arbiter;

`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req0 = 0, req1 = 0;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [3:0] sel0 = 0, sel1 = 0, sh0 = 0, sh1 = 0;

  logic        ack0_1, ack1_1, busy_1, ack0_4, ack1_4, busy_4;
  logic [7:0]  res_1, aa_1, ab_1, aout_1, res_4, aa_4, ab_4, aout_4;
  logic [3:0]  asel_1, ash_1, asel_4, ash_4;
  logic [15:0] cnt0_1, cnt1_1, cnt0_4, cnt1_4;

  int vectors = 0;
  int errors  = 0;
  bit last_m;
  int gc[2];

  // External ALU model: the arbiter only forwards operands and captures the result.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] sel, input logic [3:0] sh);
    case (sel)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      default: return ~a;
    endcase
  endfunction

  assign aout_1 = alu_f(aa_1, ab_1, asel_1, ash_1);
  assign aout_4 = alu_f(aa_4, ab_4, asel_4, ash_4);

  alu_arbiter #(.W(8), .ALU_LAT(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_req0(req0), .i_req1(req1),
    .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1),
    .i_sel0(sel0), .i_sel1(sel1), .i_sh0(sh0), .i_sh1(sh1),
    .o_ack0(ack0_1), .o_ack1(ack1_1), .o_res(res_1), .o_busy(busy_1),
    .o_alu_a(aa_1), .o_alu_b(ab_1), .o_alu_sel(asel_1), .o_alu_sh(ash_1),
    .i_alu_out(aout_1), .o_cnt0(cnt0_1), .o_cnt1(cnt1_1)
  );

  alu_arbiter #(.W(8), .ALU_LAT(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_req0(req0), .i_req1(req1),
    .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1),
    .i_sel0(sel0), .i_sel1(sel1), .i_sh0(sh0), .i_sh1(sh1),
    .o_ack0(ack0_4), .o_ack1(ack1_4), .o_res(res_4), .o_busy(busy_4),
    .o_alu_a(aa_4), .o_alu_b(ab_4), .o_alu_sel(asel_4), .o_alu_sh(ash_4),
    .i_alu_out(aout_4), .o_cnt0(cnt0_4), .o_cnt1(cnt1_4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    rst    = 1'b0;
    last_m = 1'b1;
    gc[0]  = 0;
    gc[1]  = 0;
  endtask

  task automatic rand_ops();
    a0 = 8'($urandom); b0 = 8'($urandom); sel0 = 4'($urandom_range(0, 7)); sh0 = 4'($urandom_range(0, 7));
    a1 = 8'($urandom); b1 = 8'($urandom); sel1 = 4'($urandom_range(0, 7)); sh1 = 4'($urandom_range(0, 7));
  endtask

  // Steps until either ack is seen on the selected instance; gives up after 40 cycles.
  task automatic wait_ack(input bit use4, output int n, output bit g0, output bit g1,
                          output logic [7:0] r);
    n = 0; g0 = 0; g1 = 0; r = '0;
    while (!g0 && !g1 && n < 40) begin
      step();
      n++;
      g0 = use4 ? ack0_4 : ack0_1;
      g1 = use4 ? ack1_4 : ack1_1;
      r  = use4 ? res_4  : res_1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({ack0_1, ack1_1, res_1, busy_1, aa_1, ab_1, asel_1, ash_1, cnt0_1, cnt1_1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: outputs %h, want all zero",
               {ack0_1, ack1_1, res_1, busy_1, aa_1, ab_1, asel_1, ash_1, cnt0_1, cnt1_1});
    end
    vectors++;
    if ({ack0_4, ack1_4, res_4, busy_4, aa_4, ab_4, asel_4, ash_4, cnt0_4, cnt1_4} !== '0) begin
      errors++;
      $display("FAIL reset_dut4: outputs %h, want all zero",
               {ack0_4, ack1_4, res_4, busy_4, aa_4, ab_4, asel_4, ash_4, cnt0_4, cnt1_4});
    end
  endtask

  task automatic test_single();
    do_reset();
    a0 = 8'h01; b0 = 8'h01; sel0 = 4'b0000; sh0 = 4'b0100;
    req0 = 1'b1;
    step();
    vectors++;
    if ({aa_1, ab_1, asel_1, ash_1} !== {8'h01, 8'h01, 4'h0, 4'h4}) begin
      errors++; $display("FAIL single_alu_load: got %h want 0101_04", {aa_1, ab_1, asel_1, ash_1});
    end
    vectors++;
    if ({busy_1, ack0_1, ack1_1} !== 3'b100) begin
      errors++; $display("FAIL single_exec: busy/ack0/ack1 %b want 100", {busy_1, ack0_1, ack1_1});
    end
    step();
    vectors++;
    if ({ack0_1, ack1_1, res_1} !== {2'b10, 8'h02}) begin
      errors++; $display("FAIL single_ack: ack0/ack1/res %h want 2_02", {ack0_1, ack1_1, res_1});
    end
    req0 = 1'b0;
    step();
    vectors++;
    if ({ack0_1, ack1_1, busy_1, res_1} !== {3'b000, 8'h02}) begin
      errors++; $display("FAIL single_after: ack0/ack1/busy/res %h want 0_02", {ack0_1, ack1_1, busy_1, res_1});
    end
    step();
    vectors++;
    if (busy_1 !== 1'b0) begin
      errors++; $display("FAIL single_idle: busy %b want 0", busy_1);
    end
  endtask

  task automatic test_tie();
    int n; bit g0, g1; logic [7:0] r;
    do_reset();
    a0 = 8'h01; b0 = 8'h01; sel0 = 4'd0; sh0 = 4'd0;
    a1 = 8'h02; b1 = 8'h0F; sel1 = 4'd0; sh1 = 4'd0;
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(1'b0, n, g0, g1, r);
    vectors++;
    if ({g0, g1, r, 8'(n)} !== {2'b10, 8'h02, 8'd2}) begin
      errors++; $display("FAIL tie_first: ack0/ack1 %b%b res %h lat %0d want 10 02 2", g0, g1, r, n);
    end
    req0 = 1'b0;
    wait_ack(1'b0, n, g0, g1, r);
    vectors++;
    if ({g0, g1, r, 8'(n)} !== {2'b01, 8'h11, 8'd3}) begin
      errors++; $display("FAIL tie_second: ack0/ack1 %b%b res %h gap %0d want 01 11 3", g0, g1, r, n);
    end
    req1 = 1'b0;
    step();
  endtask

  task automatic test_alternate();
    int n; bit g0, g1; logic [7:0] r, e0, e1;
    do_reset();
    rand_ops();
    e0 = alu_f(a0, b0, sel0, sh0);
    e1 = alu_f(a1, b1, sel1, sh1);
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_ack(1'b0, n, g0, g1, r);
      vectors++;
      if ({g0, g1} !== ((k % 2) ? 2'b01 : 2'b10) || r !== ((k % 2) ? e1 : e0)) begin
        errors++; $display("FAIL alternate_%0d: ack0/ack1 %b%b res %h want requester %0d res %h",
                           k, g0, g1, r, k % 2, (k % 2) ? e1 : e0);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    vectors++;
    if ({cnt0_1, cnt1_1} !== (STATS ? {16'd3, 16'd3} : 32'd0)) begin
      errors++; $display("FAIL alternate_counts: cnt0 %0d cnt1 %0d want %0d each", cnt0_1, cnt1_1, STATS ? 3 : 0);
    end
  endtask

  task automatic test_lat4();
    int n; bit g0, g1; logic [7:0] r, e0, a_g;
    do_reset();
    rand_ops();
    a_g = a0;
    e0  = alu_f(a0, b0, sel0, sh0);
    req0 = 1'b1;
    step();
    vectors++;
    if (aa_4 !== a_g) begin
      errors++; $display("FAIL lat4_load: alu_a %h want %h", aa_4, a_g);
    end
    a0 = ~a0; b0 = 8'($urandom); sel0 = sel0 ^ 4'd1;
    wait_ack(1'b1, n, g0, g1, r);
    vectors++;
    if ({g0, g1} !== 2'b10 || r !== e0 || n + 1 !== 5) begin
      errors++; $display("FAIL lat4_result: ack0/ack1 %b%b res %h lat %0d want 10 %h 5", g0, g1, r, n + 1, e0);
    end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_drop();
    int n; bit g0, g1; logic [7:0] r, e0;
    do_reset();
    rand_ops();
    e0 = alu_f(a0, b0, sel0, sh0);
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    wait_ack(1'b0, n, g0, g1, r);
    vectors++;
    if ({g0, g1} !== 2'b10 || r !== e0 || n !== 1) begin
      errors++; $display("FAIL drop_ack: ack0/ack1 %b%b res %h wait %0d want 10 %h 1", g0, g1, r, n, e0);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({busy_1, ack0_1, ack1_1} !== 3'b000) begin
        errors++; $display("FAIL drop_idle_%0d: busy/ack0/ack1 %b want 000", k, {busy_1, ack0_1, ack1_1});
      end
    end
  endtask

  task automatic test_reset_mid();
    int n; bit g0, g1; logic [7:0] r;
    do_reset();
    rand_ops();
    req0 = 1'b1;
    step();
    step();
    vectors++;
    if (busy_4 !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: busy %b want 1", busy_4);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({ack0_4, ack1_4, res_4, busy_4, aa_4, ab_4, asel_4, ash_4, cnt0_4, cnt1_4} !== '0) begin
      errors++; $display("FAIL midrst_clear: outputs %h want all zero",
                         {ack0_4, ack1_4, res_4, busy_4, aa_4, ab_4, asel_4, ash_4, cnt0_4, cnt1_4});
    end
    req0 = 1'b0;
    step();
    step();
    vectors++;
    if ({ack0_4, ack1_4} !== 2'b00) begin
      errors++; $display("FAIL midrst_noack: ack0/ack1 %b want 00", {ack0_4, ack1_4});
    end
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(1'b1, n, g0, g1, r);
    vectors++;
    if ({g0, g1} !== 2'b10 || n !== 5) begin
      errors++; $display("FAIL midrst_first: ack0/ack1 %b%b lat %0d want 10 5", g0, g1, n);
    end
    req0 = 1'b0;
    wait_ack(1'b1, n, g0, g1, r);
    req1 = 1'b0;
    step();
  endtask

  task automatic test_random();
    int n, lat; bit g0, g1, first; logic [7:0] r, e0, e1; logic [1:0] mask;
    for (int d = 0; d < 2; d++) begin
      do_reset();
      lat = d ? 4 : 1;
      for (int it = 0; it < 12; it++) begin
        rand_ops();
        e0 = alu_f(a0, b0, sel0, sh0);
        e1 = alu_f(a1, b1, sel1, sh1);
        mask  = 2'($urandom_range(1, 3));
        req0  = mask[0];
        req1  = mask[1];
        first = (mask == 2'b11) ? !last_m : (mask == 2'b10);
        wait_ack(d[0], n, g0, g1, r);
        vectors++;
        if ({g0, g1} !== (first ? 2'b01 : 2'b10) || r !== (first ? e1 : e0) || n !== lat + 1) begin
          errors++; $display("FAIL random_d%0d_%0d_a: ack0/ack1 %b%b res %h lat %0d want req%0d res %h lat %0d",
                             d, it, g0, g1, r, n, first, first ? e1 : e0, lat + 1);
        end
        last_m = first;
        gc[first]++;
        if (first) req1 = 1'b0; else req0 = 1'b0;
        if (mask == 2'b11) begin
          wait_ack(d[0], n, g0, g1, r);
          vectors++;
          if ({g0, g1} !== (!first ? 2'b01 : 2'b10) || r !== (!first ? e1 : e0) || n !== lat + 2) begin
            errors++; $display("FAIL random_d%0d_%0d_b: ack0/ack1 %b%b res %h gap %0d want req%0d res %h gap %0d",
                               d, it, g0, g1, r, n, !first, !first ? e1 : e0, lat + 2);
          end
          last_m = !first;
          gc[!first]++;
          req0 = 1'b0; req1 = 1'b0;
        end
        step();
        vectors++;
        if ((d ? {ack0_4, ack1_4} : {ack0_1, ack1_1}) !== 2'b00) begin
          errors++; $display("FAIL random_d%0d_%0d_pulse: ack still high after one cycle", d, it);
        end
      end
      vectors++;
      if ((d ? {cnt0_4, cnt1_4} : {cnt0_1, cnt1_1}) !== (STATS ? {16'(gc[0]), 16'(gc[1])} : 32'd0)) begin
        errors++; $display("FAIL random_d%0d_counts: cnt %h want %0d/%0d", d,
                           d ? {cnt0_4, cnt1_4} : {cnt0_1, cnt1_1}, STATS ? gc[0] : 0, STATS ? gc[1] : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_alternate();
    test_lat4();
    test_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 8-bit ALU datapath (operands A/B, 4-bit op select, 4-bit shift amount, 8-bit result). Each requester presents a complete operation; the block grants one at a time (round-robin), drives the ALU input registers, waits a fixed settle latency, captures the result and returns it with a one-cycle acknowledge. The ALU sits outside this block and connects through the `alu_*` ports.

## Interface
- `W`, 8, operand/result width
- `ALU_LAT`, 1, cycles the ALU output is allowed to settle before capture (legal range 1..15)
- `clk` input 1 system clock, rising edge
- `reset` input 1 asynchronous, active-high reset
- `req0`, `req1` input 1 request from requester 0/1, held until matching ack
- `a0`, `b0`, `a1`, `b1` input W operands per requester
- `sel0`, `sel1` input 4 op select per requester
- `sh0`, `sh1` input 4 shift amount per requester
- `ack0`, `ack1` output 1 one-cycle completion pulse
- `res` output W captured result, valid while ack0/ack1 high, held afterwards
- `busy` output 1 high in EXEC and DONE
- `alu_a`, `alu_b` output W registered operands to ALU
- `alu_sel`, `alu_sh` output 4 registered select/shift to ALU
- `alu_out` input W combinational ALU result
- `cnt0`, `cnt1` output 16 grant counters (see Configuration)

## Operation
- Reset: state IDLE, all outputs 0, `last` = 1 (so requester 0 wins first tie), latency counter 0.
- FSM states IDLE, EXEC, DONE.
- IDLE: if any req high, grant at the clock edge: only one high -> that one; both high -> the one != `last`. At the grant edge latch its a/b/sel/sh into `alu_*`, record `gnt`, set `last` = `gnt`, load counter = ALU_LAT-1, go EXEC. No req -> stay IDLE, `alu_*` hold previous values.
- EXEC: counter decrements each edge; when counter == 0, capture `alu_out` into `res` at that edge and go DONE.
- DONE: `ack[gnt]` = 1 for exactly this cycle; other ack 0; next edge -> IDLE unconditionally.
- Operands are sampled only at the grant edge; changes afterwards do not affect the operation. Dropping req after grant does not cancel: ack still pulses.
- Req still high in IDLE after its ack counts as a new request.
- Both held continuously -> strict alternation 0,1,0,1...
- `alu_out` is W bits; no carry/overflow handling here, captured verbatim.
- Asynchronous reset mid-EXEC or mid-DONE: operation aborted, no ack, all outputs return to reset values immediately.

## Timing
- Grant edge E: `alu_*` valid from E. Capture edge E+ALU_LAT. Ack high during cycle after E+ALU_LAT. IDLE reached at E+ALU_LAT+1.
- Request-to-ack latency: ALU_LAT+1 cycles from grant edge; requester seeing ack must drop req before the next edge to avoid a repeat.
- Throughput: one operation per ALU_LAT+2 cycles (ALU_LAT=1 -> 3 cycles).
- `ack0`, `ack1`, `busy`, `res`, `alu_*` are all registered/state-decoded; no combinational path from req or operands to any output.

## Configuration
- `ALU_ARB_STATS_EN` defined: `cnt0`/`cnt1` increment by 1 at every grant edge to requester 0/1, wrap 16'hFFFF -> 0, cleared by reset.
- Not defined: counter logic absent, `cnt0`/`cnt1` tied to 0.

## Test plan
- Reset asserted mid-EXEC -> all outputs 0 immediately, no ack; after release req0 granted first.
- req0 only, a0=1, b0=1, sel0=0000, sh0=0100, ALU_LAT=1 -> `alu_*` loaded at grant edge, ack0 high exactly one cycle 2 cycles after grant, res=8'h02, ack1 stays 0.
- req0 and req1 raised same cycle (a1=2, b1=8'h0F) -> requester 0 served first (res=2), then requester 1 (res=8'h11); acks never overlap.
- Both held for 6 operations -> grant order 0,1,0,1,0,1; with `ALU_ARB_STATS_EN` cnt0=3, cnt1=3; without, both 0.
- ALU_LAT=4, operands changed one cycle after grant -> `res` reflects operands at grant edge, ack 5 cycles after grant.
- req0 dropped one cycle after grant -> ack0 still pulses, state returns to IDLE, no second grant.
